// File: rtl/rx_uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encodings,
// parity-mode constants, oversampling constants and the majority-vote helper.
package rx_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rxState_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_TICK = 9;
    localparam int TICK_W      = $clog2(OVERSAMPLE);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_uart_fifo.sv
// First-word-fall-through FIFO with count-based status flags. A push and a
// read in the same cycle both take effect, including when empty or full.
module rx_uart_fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             read,
    output logic [WIDTH-1:0] headData,
    output logic             dataPresent,
    output logic             halfFull,
    output logic             full
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [LOG2_DEPTH-1:0] wrPtr_r;
    logic [LOG2_DEPTH-1:0] rdPtr_r;
    logic [LOG2_DEPTH:0]   count_r;
    logic                  doRead_s;
    logic                  doWrite_s;
    logic                  isEmpty_s;
    logic                  isFull_s;

    // Access qualification: an empty FIFO read only succeeds when a push bypasses it
    always_comb begin
        isEmpty_s = (count_r == (LOG2_DEPTH+1)'(0));
        isFull_s  = (count_r == (LOG2_DEPTH+1)'(DEPTH));
        doRead_s  = read && (!isEmpty_s || push);
        doWrite_s = push && (!isFull_s || read);
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (doWrite_s) wrPtr_r <= wrPtr_r + LOG2_DEPTH'(1);
            if (doRead_s)  rdPtr_r <= rdPtr_r + LOG2_DEPTH'(1);
            count_r <= count_r + (LOG2_DEPTH+1)'(doWrite_s) - (LOG2_DEPTH+1)'(doRead_s);
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (doWrite_s) mem_r[wrPtr_r] <= pushData;
    end

    // Head word and status, forced to zero while empty
    always_comb begin
        headData    = isEmpty_s ? '0 : mem_r[rdPtr_r];
        dataPresent = !isEmpty_s;
        halfFull    = (count_r >= (LOG2_DEPTH+1)'(DEPTH / 2));
        full        = isFull_s;
    end

endmodule

// File: rtl/rx_uart_cfg.sv
// Configurable 16x-oversampled UART receiver feeding a FWFT FIFO.
// Define RX_UART_CFG_ERR_FLAGS_EN to store errored frames with frameErr/parityErr flags.
module rx_uart_cfg
    import rx_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x16BaudStrobe,
    input  logic                 serialIn,
    input  logic                 read,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataPresent,
    output logic                 halfFull,
    output logic                 full,
`ifdef RX_UART_CFG_ERR_FLAGS_EN
    output logic                 frameErr,
    output logic                 parityErr,
`endif
    output logic                 overrun
);

`ifdef RX_UART_CFG_ERR_FLAGS_EN
    localparam int ENTRY_W = DATA_BITS + 2;
`else
    localparam int ENTRY_W = DATA_BITS;
`endif

    rxState_t             state_r, stateNext_s;
    logic                 rxMeta_r, rxSync_r, lineLast_r;
    logic [TICK_W-1:0]    tick_r;
    logic [3:0]           bitCnt_r;
    logic                 sample7_r, sample8_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parityErr_r, frameErr_r;
    logic                 pushReq_r, overrun_r;
    logic [ENTRY_W-1:0]   pushData_r, entry_s, head_s;
    logic                 bitVal_s, atSample_s, fallEdge_s, lastData_s, lastStop_s;
    logic                 shiftEn_s, parityChk_s, stopChk_s, frameDone_s;
    logic                 parityBad_s, frameErrFinal_s, pushNow_s;
    logic                 fifoFull_s, fifoPresent_s;

    assign bitVal_s        = majority3(sample7_r, sample8_r, rxSync_r);
    assign atSample_s      = x16BaudStrobe && (tick_r == TICK_W'(SAMPLE_TICK));
    assign fallEdge_s      = x16BaudStrobe && lineLast_r && !rxSync_r;
    assign lastData_s      = (bitCnt_r == 4'(DATA_BITS - 1));
    assign lastStop_s      = (bitCnt_r == 4'(STOP_BITS - 1));
    assign parityBad_s     = (PARITY == PARITY_EVEN) ? (^shift_r ^ bitVal_s) : ~(^shift_r ^ bitVal_s);
    assign frameErrFinal_s = frameErr_r | ~bitVal_s;

    // Line synchroniser and strobe-aligned edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_r   <= 1'b1;
            rxSync_r   <= 1'b1;
            lineLast_r <= 1'b1;
        end else begin
            rxMeta_r <= serialIn;
            rxSync_r <= rxMeta_r;
            if (x16BaudStrobe) lineLast_r <= rxSync_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= stateNext_s;
    end

    // FSM next-state logic; bit decisions happen only at the tick-9 strobe
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_IDLE:      if (fallEdge_s) stateNext_s = ST_START; else stateNext_s = ST_IDLE;
            ST_START:     if (atSample_s) stateNext_s = bitVal_s ? ST_IDLE : ST_DATA;
                          else stateNext_s = ST_START;
            ST_DATA:      if (atSample_s && lastData_s)
                              stateNext_s = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                          else stateNext_s = ST_DATA;
            ST_PARITY:    if (atSample_s) stateNext_s = ST_STOP; else stateNext_s = ST_PARITY;
            ST_STOP:      if (atSample_s && lastStop_s) stateNext_s = ST_WAIT_HIGH;
                          else stateNext_s = ST_STOP;
            ST_WAIT_HIGH: if (rxSync_r) stateNext_s = ST_IDLE; else stateNext_s = ST_WAIT_HIGH;
            default:      stateNext_s = ST_IDLE;
        endcase
    end

    // FSM outputs: per-state sampling strobes and the frame-complete decision
    always_comb begin
        shiftEn_s   = 1'b0;
        parityChk_s = 1'b0;
        stopChk_s   = 1'b0;
        case (state_r)
            ST_DATA:   shiftEn_s   = atSample_s;
            ST_PARITY: parityChk_s = atSample_s;
            ST_STOP:   stopChk_s   = atSample_s;
            default:   shiftEn_s   = 1'b0;
        endcase
        frameDone_s = stopChk_s && lastStop_s;
`ifdef RX_UART_CFG_ERR_FLAGS_EN
        entry_s   = {frameErrFinal_s, parityErr_r, shift_r};
        pushNow_s = frameDone_s;
`else
        entry_s   = shift_r;
        pushNow_s = frameDone_s && !frameErrFinal_s && !parityErr_r;
`endif
    end

    // Oversampling datapath: tick counter, vote samples, shifter and error capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r      <= '0;
            bitCnt_r    <= 4'd0;
            sample7_r   <= 1'b1;
            sample8_r   <= 1'b1;
            shift_r     <= '0;
            parityErr_r <= 1'b0;
            frameErr_r  <= 1'b0;
            pushReq_r   <= 1'b0;
            pushData_r  <= '0;
        end else begin
            pushReq_r <= pushNow_s;
            if (frameDone_s) pushData_r <= entry_s;
            if (state_r == ST_IDLE) begin
                tick_r      <= '0;
                bitCnt_r    <= 4'd0;
                parityErr_r <= 1'b0;
                frameErr_r  <= 1'b0;
            end else if (x16BaudStrobe) begin
                tick_r <= tick_r + TICK_W'(1);
                if (tick_r == TICK_W'(SAMPLE_TICK - 2)) sample7_r <= rxSync_r;
                if (tick_r == TICK_W'(SAMPLE_TICK - 1)) sample8_r <= rxSync_r;
                if (atSample_s) bitCnt_r <= (stateNext_s != state_r) ? 4'd0 : bitCnt_r + 4'd1;
                if (shiftEn_s) shift_r <= {bitVal_s, shift_r[DATA_BITS-1:1]};
                if (parityChk_s) parityErr_r <= parityBad_s;
                if (stopChk_s && !bitVal_s) frameErr_r <= 1'b1;
            end
        end
    end

    // Sticky overrun: set on a dropped push, cleared by a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     overrun_r <= 1'b0;
        else if (pushReq_r && fifoFull_s && !read)   overrun_r <= 1'b1;
        else if (read)                               overrun_r <= 1'b0;
        else                                         overrun_r <= overrun_r;
    end

    rx_uart_fifo #(
        .WIDTH      (ENTRY_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) uFifo (
        .clk         (clk),
        .rst         (rst),
        .push        (pushReq_r),
        .pushData    (pushData_r),
        .read        (read),
        .headData    (head_s),
        .dataPresent (fifoPresent_s),
        .halfFull    (halfFull),
        .full        (fifoFull_s)
    );

    assign dataOut     = head_s[DATA_BITS-1:0];
    assign dataPresent = fifoPresent_s;
    assign full        = fifoFull_s;
    assign overrun     = overrun_r;
`ifdef RX_UART_CFG_ERR_FLAGS_EN
    assign parityErr   = head_s[DATA_BITS];
    assign frameErr    = head_s[DATA_BITS+1];
`endif

endmodule
